// File: rtl/spatz_pkg.sv
// Shared Spatz types and constants used by the VRF write-port arbiter and its
// round-robin picker.
package spatz_pkg;

  localparam int unsigned NrVRFWriters = 3;

  typedef logic [9:0]  vreg_addr_t;
  typedef logic [63:0] vreg_data_t;
  typedef logic [7:0]  vreg_be_t;

  typedef enum logic [1:0] {
    VFU_W  = 2'd0,
    VLSU_W = 2'd1,
    SLD_W  = 2'd2
  } vrf_writer_e;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } warb_state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spatz_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping modulo NrReq. Shared with the future read-port arbiter.
module spatz_rr_pick
  import spatz_pkg::*;
#(
  parameter int unsigned NrReq    = 2,
  parameter int unsigned IdxWidth = idx_width(NrReq)
) (
  input  logic [NrReq-1:0]    req_i,
  input  logic [IdxWidth-1:0] ptr_i,
  output logic [IdxWidth-1:0] idx_o,
  output logic                found_o
);

  logic [IdxWidth:0] cand;

  // Scan from the farthest offset down so the nearest hit to ptr_i wins last.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int i = NrReq - 1; i >= 0; i--) begin
      cand = {1'b0, ptr_i} + (IdxWidth+1)'(i);
      if (cand >= (IdxWidth+1)'(NrReq)) cand = cand - (IdxWidth+1)'(NrReq);
      if (req_i[cand[IdxWidth-1:0]]) begin
        found_o = 1'b1;
        idx_o   = cand[IdxWidth-1:0];
      end
    end
  end

endmodule

// File: rtl/spatz_vrf_wport_arbiter.sv
// Round-robin arbiter sharing the single VRF write port; a grant holds until the
// VRF acks. Optional counters are enabled by SPATZ_VRF_WARB_PERF_EN.
module spatz_vrf_wport_arbiter
  import spatz_pkg::*;
#(
  parameter int unsigned NrReq    = NrVRFWriters,
  parameter int unsigned IdxWidth = idx_width(NrReq)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NrReq-1:0]         req_we_i,
  input  vreg_addr_t [NrReq-1:0]   req_waddr_i,
  input  vreg_data_t [NrReq-1:0]   req_wdata_i,
  input  vreg_be_t   [NrReq-1:0]   req_wbe_i,
  output logic [NrReq-1:0]         req_wvalid_o,
  output logic                     vrf_we_o,
  output vreg_addr_t               vrf_waddr_o,
  output vreg_data_t               vrf_wdata_o,
  output vreg_be_t                 vrf_wbe_o,
  input  logic                     vrf_wvalid_i,
  output logic [IdxWidth-1:0]      gnt_idx_o,
  output logic                     busy_o
`ifdef SPATZ_VRF_WARB_PERF_EN
  ,
  output logic [NrReq-1:0][31:0]   perf_cnt_o,
  output logic [31:0]              stall_cnt_o
`endif
);

  warb_state_e         state_q, state_d;
  logic [IdxWidth-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxWidth-1:0] lock_idx_q, lock_idx_d;
  logic [IdxWidth-1:0] win_idx, sel_idx;
  logic                win_found, drive;

  spatz_rr_pick #(
    .NrReq    (NrReq),
    .IdxWidth (IdxWidth)
  ) i_rr_pick (
    .req_i   (req_we_i),
    .ptr_i   (rr_ptr_q),
    .idx_o   (win_idx),
    .found_o (win_found)
  );

  function automatic logic [IdxWidth-1:0] rr_next(input logic [IdxWidth-1:0] i);
    return (i == IdxWidth'(NrReq - 1)) ? '0 : i + 1'b1;
  endfunction

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_idx_d = lock_idx_q;
    sel_idx    = '0;
    drive      = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          drive   = 1'b1;
          sel_idx = win_idx;
          if (vrf_wvalid_i) rr_ptr_d = rr_next(win_idx);
          else begin
            lock_idx_d = win_idx;
            state_d    = LOCK;
          end
        end
      end
      LOCK: begin
        // A locked requester dropping its request is a protocol error: release without writing.
        if (req_we_i[lock_idx_q]) begin
          drive   = 1'b1;
          sel_idx = lock_idx_q;
          if (vrf_wvalid_i) begin
            rr_ptr_d = rr_next(lock_idx_q);
            state_d  = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  assign vrf_we_o     = drive && !rst_i;
  assign vrf_waddr_o  = vrf_we_o ? req_waddr_i[sel_idx] : '0;
  assign vrf_wdata_o  = vrf_we_o ? req_wdata_i[sel_idx] : '0;
  assign vrf_wbe_o    = vrf_we_o ? req_wbe_i[sel_idx]   : '0;
  assign gnt_idx_o    = vrf_we_o ? sel_idx : '0;
  assign req_wvalid_o = (vrf_we_o && vrf_wvalid_i) ? (NrReq'(1) << sel_idx) : '0;
  assign busy_o       = (state_q == LOCK) && !rst_i;

`ifdef SPATZ_VRF_WARB_PERF_EN
  logic [31:0] perf_q [NrReq];

  for (genvar g = 0; g < NrReq; g++) begin : g_perf
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) perf_q[g] <= '0;
      else if (req_wvalid_o[g] && perf_q[g] != '1) perf_q[g] <= perf_q[g] + 32'd1;
    end
    assign perf_cnt_o[g] = perf_q[g];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) stall_cnt_o <= '0;
    else if (vrf_we_o && !vrf_wvalid_i && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 32'd1;
  end
`endif

`ifndef SYNTHESIS
  a_lock_held: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == LOCK) |-> req_we_i[lock_idx_q])
    else $error("locked requester dropped its write request before ack");
  a_stray_ack: assert property (@(posedge clk_i) disable iff (rst_i)
    vrf_wvalid_i |-> vrf_we_o)
    else $warning("vrf_wvalid_i asserted with no write in flight");
`endif

endmodule

// File: tb/tb_spatz_vrf_wport_arbiter.sv
// Directed bench for the VRF write-port arbiter; define SPATZ_VRF_WARB_PERF_EN
// to also exercise the performance counters.
module tb_spatz_vrf_wport_arbiter;
  import spatz_pkg::*;

  localparam int unsigned N = 3;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic [N-1:0]         req_we_i;
  vreg_addr_t [N-1:0]   req_waddr_i;
  vreg_data_t [N-1:0]   req_wdata_i;
  vreg_be_t   [N-1:0]   req_wbe_i;
  logic [N-1:0]         req_wvalid_o;
  logic                 vrf_we_o;
  vreg_addr_t           vrf_waddr_o;
  vreg_data_t           vrf_wdata_o;
  vreg_be_t             vrf_wbe_o;
  logic                 vrf_wvalid_i;
  logic [1:0]           gnt_idx_o;
  logic                 busy_o;
`ifdef SPATZ_VRF_WARB_PERF_EN
  logic [N-1:0][31:0]   perf_cnt_o;
  logic [31:0]          stall_cnt_o;
`endif

  int vecs = 0;
  int errs = 0;

  vreg_addr_t addr_tab [N] = '{10'h010, 10'h021, 10'h032};
  vreg_data_t data_tab [N] = '{64'hA000_0000_0000_0010, 64'hB000_0000_0000_0021, 64'hC000_0000_0000_0032};
  vreg_be_t   be_tab   [N] = '{8'hFF, 8'h0F, 8'hF0};

  spatz_vrf_wport_arbiter dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_we_i     (req_we_i),
    .req_waddr_i  (req_waddr_i),
    .req_wdata_i  (req_wdata_i),
    .req_wbe_i    (req_wbe_i),
    .req_wvalid_o (req_wvalid_o),
    .vrf_we_o     (vrf_we_o),
    .vrf_waddr_o  (vrf_waddr_o),
    .vrf_wdata_o  (vrf_wdata_o),
    .vrf_wbe_o    (vrf_wbe_o),
    .vrf_wvalid_i (vrf_wvalid_i),
    .gnt_idx_o    (gnt_idx_o),
    .busy_o       (busy_o)
`ifdef SPATZ_VRF_WARB_PERF_EN
    ,
    .perf_cnt_o   (perf_cnt_o),
    .stall_cnt_o  (stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; req_we_i = 3'b111; vrf_wvalid_i = 1'b1;
    #2;
    vecs++; if (vrf_we_o !== 1'b0) begin errs++; $display("FAIL reset_we got %0b want 0", vrf_we_o); end
    vecs++; if (req_wvalid_o !== 3'b000) begin errs++; $display("FAIL reset_wvalid got %b want 000", req_wvalid_o); end
    vecs++; if (busy_o !== 1'b0) begin errs++; $display("FAIL reset_busy got %0b want 0", busy_o); end
    vecs++; if (vrf_waddr_o !== 10'h0 || vrf_wdata_o !== 64'h0 || gnt_idx_o !== 2'd0)
      begin errs++; $display("FAIL reset_port got addr %h data %h gnt %0d want 0", vrf_waddr_o, vrf_wdata_o, gnt_idx_o); end
    next_cycle();
    rst_i = 1'b0; req_we_i = 3'b000; vrf_wvalid_i = 1'b0;
    #2;
    vecs++; if (vrf_we_o !== 1'b0 || vrf_waddr_o !== 10'h0)
      begin errs++; $display("FAIL idle_noreq got we %0b addr %h want 0 0", vrf_we_o, vrf_waddr_o); end
  endtask

  task automatic test_single();
    next_cycle();
    req_we_i = 3'b001; vrf_wvalid_i = 1'b1;
    #2;
    vecs++; if (vrf_we_o !== 1'b1) begin errs++; $display("FAIL single_we got %0b want 1", vrf_we_o); end
    vecs++; if (vrf_waddr_o !== 10'h010) begin errs++; $display("FAIL single_addr got %h want 010", vrf_waddr_o); end
    vecs++; if (vrf_wbe_o !== 8'hFF || vrf_wdata_o !== 64'hA000_0000_0000_0010)
      begin errs++; $display("FAIL single_data got be %h data %h want ff a000000000000010", vrf_wbe_o, vrf_wdata_o); end
    vecs++; if (req_wvalid_o !== 3'b001) begin errs++; $display("FAIL single_pulse got %b want 001", req_wvalid_o); end
    next_cycle();
    req_we_i = 3'b011;
    #2;
    vecs++; if (gnt_idx_o !== 2'd1 || req_wvalid_o !== 3'b010)
      begin errs++; $display("FAIL single_ptr1 got gnt %0d pulse %b want 1 010", gnt_idx_o, req_wvalid_o); end
  endtask

  task automatic test_wrap();
    next_cycle();
    req_we_i = 3'b011; vrf_wvalid_i = 1'b1;
    #2;
    vecs++; if (gnt_idx_o !== 2'd0 || req_wvalid_o !== 3'b001 || vrf_waddr_o !== 10'h010)
      begin errs++; $display("FAIL wrap got gnt %0d pulse %b addr %h want 0 001 010", gnt_idx_o, req_wvalid_o, vrf_waddr_o); end
  endtask

  task automatic test_round_robin();
    next_cycle();
    rst_i = 1'b1; req_we_i = 3'b000; vrf_wvalid_i = 1'b0;
    next_cycle();
    rst_i = 1'b0; req_we_i = 3'b111; vrf_wvalid_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #2;
      vecs++;
      if (gnt_idx_o !== 2'(k % 3) || req_wvalid_o !== (3'b001 << (k % 3)) || vrf_waddr_o !== addr_tab[k % 3])
        begin errs++; $display("FAIL rr_step%0d got gnt %0d pulse %b addr %h want %0d %b %h", k,
          gnt_idx_o, req_wvalid_o, vrf_waddr_o, k % 3, 3'b001 << (k % 3), addr_tab[k % 3]); end
      next_cycle();
    end
  endtask

  task automatic test_lock();
    req_we_i = 3'b010; vrf_wvalid_i = 1'b0;
    #2;
    vecs++; if (vrf_we_o !== 1'b1 || gnt_idx_o !== 2'd1 || req_wvalid_o !== 3'b000 || busy_o !== 1'b0)
      begin errs++; $display("FAIL lock_grant got we %0b gnt %0d pulse %b busy %0b want 1 1 000 0",
        vrf_we_o, gnt_idx_o, req_wvalid_o, busy_o); end
    next_cycle();
    req_we_i = 3'b111;
    for (int k = 0; k < 3; k++) begin
      #2;
      vecs++;
      if (busy_o !== 1'b1 || gnt_idx_o !== 2'd1 || req_wvalid_o !== 3'b000 || vrf_waddr_o !== 10'h021)
        begin errs++; $display("FAIL lock_hold%0d got busy %0b gnt %0d pulse %b addr %h want 1 1 000 021",
          k, busy_o, gnt_idx_o, req_wvalid_o, vrf_waddr_o); end
      next_cycle();
    end
    vrf_wvalid_i = 1'b1;
    #2;
    vecs++; if (req_wvalid_o !== 3'b010 || gnt_idx_o !== 2'd1 || busy_o !== 1'b1)
      begin errs++; $display("FAIL lock_ack got pulse %b gnt %0d busy %0b want 010 1 1", req_wvalid_o, gnt_idx_o, busy_o); end
    next_cycle();
    #2;
    vecs++; if (busy_o !== 1'b0 || gnt_idx_o !== 2'd2 || req_wvalid_o !== 3'b100 || vrf_wbe_o !== 8'hF0)
      begin errs++; $display("FAIL lock_after got busy %0b gnt %0d pulse %b be %h want 0 2 100 f0",
        busy_o, gnt_idx_o, req_wvalid_o, vrf_wbe_o); end
    next_cycle();
  endtask

  task automatic test_reset_in_lock();
    req_we_i = 3'b100; vrf_wvalid_i = 1'b0;
    #2;
    vecs++; if (gnt_idx_o !== 2'd2 || vrf_we_o !== 1'b1)
      begin errs++; $display("FAIL rlock_grant got gnt %0d we %0b want 2 1", gnt_idx_o, vrf_we_o); end
    next_cycle();
    #2;
    vecs++; if (busy_o !== 1'b1 || gnt_idx_o !== 2'd2)
      begin errs++; $display("FAIL rlock_busy got busy %0b gnt %0d want 1 2", busy_o, gnt_idx_o); end
    rst_i = 1'b1;
    #1;
    vecs++; if (vrf_we_o !== 1'b0 || busy_o !== 1'b0 || req_wvalid_o !== 3'b000 || gnt_idx_o !== 2'd0 || vrf_waddr_o !== 10'h0)
      begin errs++; $display("FAIL rlock_clear got we %0b busy %0b pulse %b gnt %0d addr %h want all 0",
        vrf_we_o, busy_o, req_wvalid_o, gnt_idx_o, vrf_waddr_o); end
    next_cycle();
    rst_i = 1'b0; req_we_i = 3'b110; vrf_wvalid_i = 1'b1;
    #2;
    vecs++; if (gnt_idx_o !== 2'd1 || req_wvalid_o !== 3'b010 || busy_o !== 1'b0)
      begin errs++; $display("FAIL rlock_after got gnt %0d pulse %b busy %0b want 1 010 0", gnt_idx_o, req_wvalid_o, busy_o); end
    next_cycle();
    req_we_i = 3'b000; vrf_wvalid_i = 1'b0;
  endtask

`ifdef SPATZ_VRF_WARB_PERF_EN
  task automatic test_perf();
    rst_i = 1'b1;
    next_cycle();
    rst_i = 1'b0; req_we_i = 3'b001;
    for (int k = 0; k < 5; k++) begin
      if (k != 1 && k != 3) begin
        vrf_wvalid_i = 1'b0;
        next_cycle();
      end
      vrf_wvalid_i = 1'b1;
      next_cycle();
    end
    req_we_i = 3'b000; vrf_wvalid_i = 1'b0;
    #2;
    vecs++; if (perf_cnt_o[0] !== 32'd5) begin errs++; $display("FAIL perf_vfu got %0d want 5", perf_cnt_o[0]); end
    vecs++; if (perf_cnt_o[1] !== 32'd0 || perf_cnt_o[2] !== 32'd0)
      begin errs++; $display("FAIL perf_others got %0d %0d want 0 0", perf_cnt_o[1], perf_cnt_o[2]); end
    vecs++; if (stall_cnt_o !== 32'd3) begin errs++; $display("FAIL perf_stall got %0d want 3", stall_cnt_o); end
  endtask
`endif

  initial begin
    for (int i = 0; i < N; i++) begin
      req_waddr_i[i] = addr_tab[i];
      req_wdata_i[i] = data_tab[i];
      req_wbe_i[i]   = be_tab[i];
    end
    test_reset();
    test_single();
    test_wrap();
    test_round_robin();
    test_lock();
    test_reset_in_lock();
`ifdef SPATZ_VRF_WARB_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
